// File: rtl/load_store_unit.sv
// Load/store stage: one bus access per request with byte-lane steering, load extension and timeout.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q, lane_q;

  logic        illegal;
  logic [1:0]  lane;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] shifted;
  logic [31:0] ld_val;

  // Decode the incoming request: legality, effective lane, enables and replicated data
  always_comb begin
    illegal = (size == 2'b11);
    lane    = addr[1:0];
    be_n    = 4'b0001;
    wd_n    = {4{wdata[7:0]}};
    case (size)
      2'b01: begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (addr[0]) illegal = 1'b1;
`endif
        lane = {addr[1], 1'b0};
        be_n = 4'b0011;
        wd_n = {2{wdata[15:0]}};
      end
      2'b10: begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (addr[1:0] != 2'b00) illegal = 1'b1;
`endif
        lane = 2'b00;
        be_n = 4'b1111;
        wd_n = wdata;
      end
      default: ;
    endcase
    be_n = be_n << lane;
  end

  assign shifted = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   ld_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      rdata     <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          we_q   <= we;
          size_q <= size;
          uns_q  <= uns;
          lane_q <= lane;
          cnt    <= 8'd0;
          err_q  <= illegal;
          // Illegal requests never touch the bus
          if (illegal) state <= FIN;
          else begin
            state     <= BUS;
            mem_we    <= we;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wd_n;
          end
        end
        BUS: begin
          if (mem_ack) begin
            state <= FIN;
            if (!we_q) rdata <= ld_val;
          end else if (cnt == TMAX) begin
            state <= FIN;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req = (state == BUS);
  assign done    = (state == FIN);
  assign err     = done & err_q;
  assign busy    = (state != IDLE) | start;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand sequences, randomized model check.
module tb_load_store_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, we, uns, mem_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] ref_rdata;

  int          o_done, o_req;
  logic        o_err, o_we, o_unstable;
  logic [31:0] o_rd, o_addr, o_wd;
  logic [3:0]  o_be;

  typedef struct {
    logic w; logic [1:0] sz; logic u;
    logic [31:0] a, wd, mrd; int lat;
    logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wd, e_rd;
    logic e_err; int e_done, e_req;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request; lat = bus cycle (1-based) on which ack is returned, 0 = never
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, wd, mrd, input int lat, input logic junk);
    bit first = 1;
    @(negedge clk);
    mem_ack = 1'b0; we = w; size = sz; uns = u; addr = a; wdata = wd; start = 1'b1;
    #1 chk("busy_accept", {31'd0, busy}, 32'd1);
    o_done = -1; o_req = 0; o_err = 1'b0; o_rd = 32'd0; o_unstable = 1'b0;
    o_addr = 32'd0; o_be = 4'd0; o_we = 1'b0; o_wd = 32'd0;
    for (int c = 1; c <= TIMEOUT + 8; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (done) begin
        o_done = c; o_err = err; o_rd = rdata; start = 1'b0;
        mem_ack = junk;
        break;
      end
      // Junk requests while busy must be ignored
      start = junk ? 1'($urandom % 2) : 1'b0;
      if (junk) begin addr = $urandom; we = 1'($urandom % 2); size = 2'($urandom % 4); end
      if (mem_req) begin
        o_req++;
        if (first) begin
          o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wd = mem_wdata; first = 0;
        end else if (mem_addr !== o_addr || mem_be !== o_be || mem_we !== o_we || mem_wdata !== o_wd)
          o_unstable = 1'b1;
        if (c == lat) begin mem_ack = 1'b1; mem_rdata = mrd; end
        else mem_rdata = $urandom;
      end
    end
  endtask

  task automatic verify(input string tag, input logic w, input int e_done, e_req, input logic e_err,
                        input logic [31:0] e_rd, e_addr, input logic [3:0] e_be, input logic [31:0] e_wd);
    chk($sformatf("%s_done_cycle", tag), o_done, e_done);
    chk($sformatf("%s_req_cycles", tag), o_req, e_req);
    chk($sformatf("%s_err", tag), {31'd0, o_err}, {31'd0, e_err});
    chk($sformatf("%s_rdata", tag), o_rd, e_rd);
    if (e_req > 0) begin
      chk($sformatf("%s_mem_addr", tag), o_addr, e_addr);
      chk($sformatf("%s_mem_be", tag), {28'd0, o_be}, {28'd0, e_be});
      chk($sformatf("%s_mem_we", tag), {31'd0, o_we}, {31'd0, w});
      chk($sformatf("%s_stable", tag), {31'd0, o_unstable}, 32'd0);
      if (w) chk($sformatf("%s_mem_wdata", tag), o_wd, e_wd);
    end
  endtask

  // Reference: aligned offset, enable mask and extension from plain arithmetic
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, wd, mrd, input int lat,
                       output logic [31:0] e_addr, output logic [3:0] e_be, output logic [31:0] e_wd,
                       output logic e_err, output int e_done, output int e_req);
    int nb, off;
    logic ill;
    longint v, span;
    ill = (sz == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd1 && a[0]) ill = 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'b00) ill = 1'b1;
`endif
    nb = 1 << sz;
    off = (int'(a % 4) / nb) * nb;
    e_addr = a - (a % 4);
    e_be = 4'(((1 << nb) - 1) << off);
    span = 64'd1 << (8 * nb);
    e_wd = (nb == 4) ? wd : 32'((longint'(wd) % span) * ((nb == 1) ? 64'h01010101 : 64'h00010001));
    if (ill) begin
      e_err = 1'b1; e_done = 1; e_req = 0;
    end else if (lat == 0) begin
      e_err = 1'b1; e_done = TIMEOUT + 1; e_req = TIMEOUT;
    end else begin
      e_err = 1'b0; e_done = lat + 1; e_req = lat;
      if (!w) begin
        v = (longint'(mrd) >> (8 * off)) % span;
        if (!u && nb < 4 && v >= span / 2) v = v - span;
        ref_rdata = 32'(v);
      end
    end
  endtask

  initial begin
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_err;
    int          e_done, e_req;

    tv[0] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1};
    tv[1] = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 1, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1};
    tv[2] = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80112233, 2, 32'h100, 4'hC, 32'h0, 32'h00008011, 1'b0, 3, 2};
    tv[3] = '{1'b1, 2'd0, 1'b0, 32'h201, 32'hA5, 32'h0, 1, 32'h200, 4'h2, 32'hA5A5A5A5, 32'h00008011, 1'b0, 2, 1};
    tv[4] = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h1234, 32'h0, 1, 32'h200, 4'hC, 32'h12341234, 32'h00008011, 1'b0, 2, 1};
`ifdef LSU_MISALIGN_TRAP_EN
    tv[5] = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 3, 32'h0, 4'h0, 32'h0, 32'h00008011, 1'b1, 1, 0};
`else
    tv[5] = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 3, 32'h100, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 4, 3};
`endif
    tv[6] = '{1'b0, 2'd3, 1'b0, 32'h104, 32'h0, 32'h55, 1, 32'h0, 4'h0, 32'h0, tv[5].e_rd, 1'b1, 1, 0};
    tv[7] = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'h0000FF00, 2, 32'h100, 4'h2, 32'h0, 32'h000000FF, 1'b0, 3, 2};

    rst_n = 1'b0; start = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    #6 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      access(tv[i].w, tv[i].sz, tv[i].u, tv[i].a, tv[i].wd, tv[i].mrd, tv[i].lat, 1'b0);
      verify($sformatf("tv%0d", i), tv[i].w, tv[i].e_done, tv[i].e_req, tv[i].e_err,
             tv[i].e_rd, tv[i].e_addr, tv[i].e_be, tv[i].e_wd);
      ref_rdata = tv[i].e_rd;
    end

    // Withheld ack: full timeout, then late acks must be ignored
    access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 0, 1'b0);
    verify("timeout", 1'b0, TIMEOUT + 1, TIMEOUT, 1'b1, ref_rdata, 32'h300, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      chk($sformatf("late_ack_req%0d", i), {31'd0, mem_req}, 32'd0);
      chk($sformatf("late_ack_done%0d", i), {31'd0, done}, 32'd0);
    end
    mem_ack = 1'b0;
    chk("late_ack_rdata", rdata, ref_rdata);

    // Reset in the middle of a bus cycle
    @(negedge clk);
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h400; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_done%0d", i), {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    ref_rdata = 32'd0;
    chk("rst_mid_rdata", rdata, 32'd0);
    access(1'b0, 2'd1, 1'b0, 32'h402, 32'h0, 32'h9ABC0000, 1, 1'b0);
    model(1'b0, 2'd1, 1'b0, 32'h402, 32'h0, 32'h9ABC0000, 1, e_addr, e_be, e_wd, e_err, e_done, e_req);
    verify("post_rst", 1'b0, e_done, e_req, e_err, ref_rdata, e_addr, e_be, e_wd);

    for (int i = 0; i < 60; i++) begin
      logic        w, u, jk;
      logic [1:0]  sz;
      logic [31:0] a, wd, mrd;
      int          lat;
      w   = 1'($urandom % 2);
      u   = 1'($urandom % 2);
      jk  = 1'($urandom % 2);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = $urandom;
      wd  = $urandom;
      mrd = $urandom;
      lat = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 4);
      access(w, sz, u, a, wd, mrd, lat, jk);
      model(w, sz, u, a, wd, mrd, lat, e_addr, e_be, e_wd, e_err, e_done, e_req);
      verify($sformatf("rnd%0d", i), w, e_done, e_req, e_err, ref_rdata, e_addr, e_be, e_wd);
    end
    mem_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU. It consumes the ALU result as an effective address, plus the store operand from the register file. It runs one load or store per request over a simple req/ack data bus, with byte-lane steering, load sign/zero extension and a bus timeout. It signals the pipeline controller with busy/done so execution stalls until the access retires.

## Interface
Parameters:
- TIMEOUT, 16: number of `mem_req` cycles without `mem_ack` before the access aborts with error; legal range 2..255.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only when `busy`=0
- we  in  1  1=store, 0=load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- uns  in  1  loads only: 1=zero-extend, 0=sign-extend
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data; low byte/half used for narrow stores
- busy  out  1  access in progress
- done  out  1  one-cycle retire pulse
- err  out  1  valid with `done`: misaligned, illegal size, or timeout
- rdata  out  32  extended load result; held until next `done`
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address, `[1:0]`=00
- mem_be  out  4  byte enables, little-endian
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid with `mem_ack`
- mem_ack  in  1  bus completion

## Operation
- Reset values: `busy`, `done`, `err`, `mem_req`, `mem_we` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0; `mem_be` = 0000; FSM state = IDLE; timeout counter = 0.
- FSM states: IDLE, BUS, FIN.
- IDLE with `start`=1 latches `we`, `size`, `uns`, `addr[1:0]`, `wdata`.
  - If the access is legal: compute lanes and go to BUS.
  - If illegal: go to FIN with err pending, and issue no bus transaction.
- BUS:
  - `mem_req`=1; `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` are stable.
  - The counter increments each cycle.
  - On `mem_ack`: capture and extend `mem_rdata` (loads only), go to FIN.
  - If the counter reaches TIMEOUT-1 without `mem_ack`: go to FIN with err.
- FIN: `done`=1 for one cycle, `err` per outcome; then return to IDLE.
- `busy`=1 in BUS and FIN, and in the cycle IDLE accepts `start`. `start` while `busy` is ignored.
- Lanes, with a = `addr[1:0]`:
  - byte: `mem_be` = 0001<<a; data replicated ×4.
  - half: `mem_be` = 0011<<a; data replicated ×2.
  - word: `mem_be` = 1111.
- Load extraction: select the byte/half at lane a, then sign- or zero-extend to 32 bits.
- Store `rdata`: unchanged.
- Error `rdata`: unchanged.
- A `mem_ack` arriving in IDLE or FIN is ignored.
- Reset asserted mid-access: `mem_req` drops asynchronously, no `done`, state = IDLE.

## Timing
- Cycle 0: `start` accepted.
- Cycle 1: first `mem_req` cycle.
- Ack at cycle k (k≥1) gives `done` at cycle k+1, with `rdata` valid from the same cycle.
- Minimum latency is start→done = 2 cycles.
- Illegal access: `done`+`err` at cycle 1, with `mem_req` never high.
- Timeout: `mem_req` is high for cycles 1..TIMEOUT, then `done`+`err` at TIMEOUT+1.
- Back-to-back: the earliest next `start` is accepted in the cycle after `done`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword with a[0]=1 is illegal.
  - A word with a≠00 is illegal.
  - Either gives the illegal-access response.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned low bits are forced aligned: half uses a&10, word uses a=00.
  - The access proceeds normally with no `err`.
- `size`=11 is illegal in both builds.

## Test plan
- LW, addr=0x100, `mem_rdata`=0xDEADBEEF, ack on first req cycle → `mem_addr`=0x100, `mem_be`=1111, `done` at cycle 2, `rdata`=0xDEADBEEF, `err`=0.
- LB signed, addr=0x103, `mem_rdata`=0x80112233 → `mem_be`=1000, `rdata`=0xFFFFFF80. LHU, addr=0x102, same data → `rdata`=0x00008011.
- SB, addr=0x201, wdata=0x000000A5 → `mem_we`=1, `mem_addr`=0x200, `mem_be`=0010, `mem_wdata`=0xA5A5A5A5. SH, addr=0x202, wdata=0x1234 → `mem_be`=1100, `mem_wdata`=0x12341234.
- Ack withheld, TIMEOUT=16 → `mem_req` high exactly 16 cycles, then `done`=1 and `err`=1; a later ack is ignored.
- LW, addr=0x102:
  - With the macro: `done`+`err` at cycle 1, `mem_req` never asserted.
  - Without the macro: access to 0x100 with `mem_be`=1111 and `err`=0.
- Reset asserted during BUS → `mem_req`=0 immediately, no `done`. A `start` after reset release completes normally.
